// File: rtl/bsg_miniblade_reset_sequencer.sv
// -----------------------------------------------------------------------------
// bsg_miniblade_reset_sequencer
//
// Sequences a reset request across els_p reset domains of a miniblade tile.
// The sequence is:
//   1. Wait for the router to drain (bounded by drain_timeout_p).
//   2. Assert every domain reset for at least hold_cycles_p cycles.
//   3. Release the domains one at a time, bit 0 first, stagger_cycles_p apart.
//
// Ports
//   clk_i        : core clock, the only clock
//   reset_i      : synchronous active-high reset; the block restarts in the
//                  hold phase, so leaving reset performs a full release
//   reset_req_i  : level reset request, already synchronized to clk_i
//   drain_idle_i : high when the router has no outstanding packets or credits
//   reset_o      : per-domain active-high resets, registered, thermometer coded
//   done_o       : high while idle, meaning all domains are out of reset
//   timeout_o    : one-cycle pulse when the drain wait expires
// -----------------------------------------------------------------------------
module bsg_miniblade_reset_sequencer #(
  parameter int els_p            = 2,
  parameter int hold_cycles_p    = 16,
  parameter int stagger_cycles_p = 4,
  parameter int drain_timeout_p  = 256
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             reset_req_i,
  input  logic             drain_idle_i,
  output logic [els_p-1:0] reset_o,
  output logic             done_o,
  output logic             timeout_o
);

  // One counter serves all timed phases, so it is sized for the longest one.
  localparam int max_hs_lp     = (hold_cycles_p > stagger_cycles_p) ? hold_cycles_p : stagger_cycles_p;
  localparam int max_cycles_lp = (max_hs_lp > drain_timeout_p) ? max_hs_lp : drain_timeout_p;
  localparam int ctr_width_lp  = ((max_cycles_lp + 1) <= 1) ? 1 : $clog2(max_cycles_lp + 1);
  localparam int idx_width_lp  = (els_p <= 1) ? 1 : $clog2(els_p);

  localparam logic [ctr_width_lp-1:0] hold_last_lp    = ctr_width_lp'(hold_cycles_p - 1);
  localparam logic [ctr_width_lp-1:0] stagger_last_lp = ctr_width_lp'(stagger_cycles_p - 1);
  localparam logic [ctr_width_lp-1:0] drain_last_lp   = ctr_width_lp'(drain_timeout_p - 1);
  localparam logic [idx_width_lp-1:0] index_last_lp   = idx_width_lp'(els_p - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    ASSERT  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e                  state_reg,   state_next;
  logic [ctr_width_lp-1:0] count_reg,   count_next;
  logic [idx_width_lp-1:0] index_reg,   index_next;
  logic [els_p-1:0]        reset_o_reg, reset_o_next;
  logic                    timeout_reg, timeout_next;

  // Reset vector after releasing domain index_reg. Lower bits are already
  // clear, so clearing only the indexed bit keeps the thermometer shape.
  logic [els_p-1:0] release_bits;

  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_release_bits
      assign release_bits[gi] = reset_o_reg[gi] & (index_reg != idx_width_lp'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg   <= ASSERT;
      count_reg   <= '0;
      index_reg   <= '0;
      reset_o_reg <= '1;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      index_reg   <= index_next;
      reset_o_reg <= reset_o_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    index_next   = index_reg;
    reset_o_next = reset_o_reg;
    timeout_next = 1'b0;

    case (state_reg)
      IDLE: begin
        reset_o_next = '0;
        // The request is latched by the state change; dropping it in DRAIN
        // does not abort the sequence.
        if (reset_req_i) begin
          state_next = DRAIN;
          count_next = '0;
        end
      end

      DRAIN: begin
        if (drain_idle_i) begin
          state_next   = ASSERT;
          reset_o_next = '1;
          count_next   = '0;
        end else if (count_reg == drain_last_lp) begin
          state_next   = ASSERT;
          reset_o_next = '1;
          count_next   = '0;
          timeout_next = 1'b1;
        end else begin
          count_next = count_reg + ctr_width_lp'(1);
        end
      end

      ASSERT: begin
        reset_o_next = '1;
        // Counter saturates at the last hold cycle so a long request cannot
        // wrap it; release waits for the request to drop.
        if (count_reg == hold_last_lp) begin
          if (!reset_req_i) begin
            state_next = RELEASE;
            count_next = '0;
            index_next = '0;
          end
        end else begin
          count_next = count_reg + ctr_width_lp'(1);
        end
      end

      RELEASE: begin
        if (reset_req_i) begin
          // Domains are already partly in reset, so skip the drain wait.
          state_next   = ASSERT;
          reset_o_next = '1;
          count_next   = '0;
          index_next   = '0;
        end else if (count_reg == stagger_last_lp) begin
          reset_o_next = release_bits;
          count_next   = '0;
          if (index_reg == index_last_lp) begin
            state_next = IDLE;
            index_next = '0;
          end else begin
            index_next = index_reg + idx_width_lp'(1);
          end
        end else begin
          count_next = count_reg + ctr_width_lp'(1);
        end
      end

      default: begin
        state_next   = ASSERT;
        reset_o_next = '1;
        count_next   = '0;
        index_next   = '0;
      end
    endcase
  end

  assign reset_o   = reset_o_reg;
  assign timeout_o = timeout_reg;
  assign done_o    = (state_reg == IDLE);

endmodule

// File: tb/tb_bsg_miniblade_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bsg_miniblade_reset_sequencer
//
// Drives two sequencers from shared inputs: instance A uses the default
// parameters (2 domains, 256-cycle drain timeout), instance B uses 3 domains
// and an 8-cycle drain timeout. A phase/elapsed-time reference model predicts
// every output of both instances after each clock edge, and directed checks
// pin down the named scenarios with literal expected values.
// -----------------------------------------------------------------------------
module tb_bsg_miniblade_reset_sequencer;

  localparam int HOLD = 16;
  localparam int STAG = 4;

  localparam int P_IDLE  = 0;
  localparam int P_DRAIN = 1;
  localparam int P_HOLD  = 2;
  localparam int P_REL   = 3;

  logic clk = 1'b0;
  logic reset_i;
  logic reset_req_i;
  logic drain_idle_i;

  logic [1:0] reset_a;
  logic       done_a;
  logic       timeout_a;
  logic [2:0] reset_b;
  logic       done_b;
  logic       timeout_b;

  int errors = 0;
  int checks = 0;

  // Reference model state, one entry per instance.
  int m_els[2] = '{2, 3};
  int m_tmo[2] = '{256, 8};
  int m_phase[2];
  int m_age[2];
  int m_rel[2];
  bit m_pulse[2];
  bit prev_to[2];

  always #5 clk = ~clk;

  bsg_miniblade_reset_sequencer #(
    .els_p(2), .hold_cycles_p(16), .stagger_cycles_p(4), .drain_timeout_p(256)
  ) dut_a (
    .clk_i(clk), .reset_i(reset_i), .reset_req_i(reset_req_i),
    .drain_idle_i(drain_idle_i), .reset_o(reset_a), .done_o(done_a),
    .timeout_o(timeout_a)
  );

  bsg_miniblade_reset_sequencer #(
    .els_p(3), .hold_cycles_p(16), .stagger_cycles_p(4), .drain_timeout_p(8)
  ) dut_b (
    .clk_i(clk), .reset_i(reset_i), .reset_req_i(reset_req_i),
    .drain_idle_i(drain_idle_i), .reset_o(reset_b), .done_o(done_b),
    .timeout_o(timeout_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model of instance m by one clock edge.
  function automatic void model_edge(int m, bit rst, bit req, bit idl);
    m_pulse[m] = 1'b0;
    if (rst) begin
      m_phase[m] = P_HOLD;
      m_age[m]   = 0;
      m_rel[m]   = 0;
    end else begin
      case (m_phase[m])
        P_IDLE: if (req) begin
          m_phase[m] = P_DRAIN;
          m_age[m]   = 0;
        end
        P_DRAIN: begin
          if (idl) begin
            m_phase[m] = P_HOLD;
            m_age[m]   = 0;
          end else if (m_age[m] + 1 == m_tmo[m]) begin
            m_phase[m] = P_HOLD;
            m_age[m]   = 0;
            m_pulse[m] = 1'b1;
          end else begin
            m_age[m]++;
          end
        end
        P_HOLD: begin
          if (m_age[m] >= HOLD - 1) begin
            if (!req) begin
              m_phase[m] = P_REL;
              m_age[m]   = 0;
              m_rel[m]   = 0;
            end
          end else begin
            m_age[m]++;
          end
        end
        default: begin
          if (req) begin
            m_phase[m] = P_HOLD;
            m_age[m]   = 0;
            m_rel[m]   = 0;
          end else if (m_age[m] + 1 == STAG) begin
            m_age[m] = 0;
            m_rel[m]++;
            if (m_rel[m] == m_els[m]) begin
              m_phase[m] = P_IDLE;
              m_rel[m]   = 0;
            end
          end else begin
            m_age[m]++;
          end
        end
      endcase
    end
  endfunction

  function automatic logic [31:0] exp_reset(int m);
    int ones;
    ones = (1 << m_els[m]) - 1;
    if (m_phase[m] == P_HOLD) return 32'(ones);
    if (m_phase[m] == P_REL)  return 32'((ones << m_rel[m]) & ones);
    return 32'd0;
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] r;
    logic [31:0] inv;
    logic [31:0] ones;
    logic        d;
    logic        t;
    for (int m = 0; m < 2; m++) begin
      r    = (m == 0) ? 32'(reset_a) : 32'(reset_b);
      d    = (m == 0) ? done_a : done_b;
      t    = (m == 0) ? timeout_a : timeout_b;
      ones = 32'((1 << m_els[m]) - 1);
      chk($sformatf("%s/i%0d/reset_o", tag, m), r, exp_reset(m));
      chk($sformatf("%s/i%0d/done_o", tag, m), 32'(d), 32'(m_phase[m] == P_IDLE));
      chk($sformatf("%s/i%0d/timeout_o", tag, m), 32'(t), 32'(m_pulse[m]));
      // Released bits must form a contiguous run from bit 0.
      inv = ~r & ones;
      chk($sformatf("%s/i%0d/thermometer", tag, m), inv & (inv + 32'd1), 32'd0);
      // In DRAIN reset_o is still zero while done_o is low, so only the
      // direction done_o -> all released is an invariant.
      chk($sformatf("%s/i%0d/done_vs_reset", tag, m), 32'(d && (r != 32'd0)), 32'd0);
      chk($sformatf("%s/i%0d/timeout_twice", tag, m), 32'(prev_to[m] && t), 32'd0);
      prev_to[m] = t;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_edge(m, reset_i, reset_req_i, drain_idle_i);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic settle(input string tag);
    for (int k = 0; k < 400 && !(m_phase[0] == P_IDLE && m_phase[1] == P_IDLE); k++)
      step(tag);
    chk({tag, "/settled_a"}, 32'(done_a), 32'd1);
    chk({tag, "/settled_b"}, 32'(done_b), 32'd1);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_phase[m] = P_HOLD;
      m_age[m]   = 0;
      m_rel[m]   = 0;
      m_pulse[m] = 1'b0;
      prev_to[m] = 1'b0;
    end
    reset_i      = 1'b1;
    reset_req_i  = 1'b0;
    drain_idle_i = 1'b1;
    @(negedge clk);

    // Power-up: reset held for 3 cycles.
    repeat (3) step("rst");
    chk("rst/reset_a", 32'(reset_a), 32'h3);
    chk("rst/reset_b", 32'(reset_b), 32'h7);
    chk("rst/done_a", 32'(done_a), 32'd0);
    chk("rst/timeout_a", 32'(timeout_a), 32'd0);
    reset_i = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      step("pwr");
      if (e <= 16) chk("pwr/hold_a", 32'(reset_a), 32'h3);
      if (e == 19) chk("pwr/e19_a", 32'(reset_a), 32'h3);
      if (e == 20) chk("pwr/e20_a", 32'(reset_a), 32'h2);
      if (e == 23) chk("pwr/e23_done_a", 32'(done_a), 32'd0);
      if (e == 24) begin
        chk("pwr/e24_a", 32'(reset_a), 32'h0);
        chk("pwr/e24_done_a", 32'(done_a), 32'd1);
      end
    end
    settle("pwr_settle");
    $display("txn power-up: errors=%0d checks=%0d", errors, checks);

    // Drain then reset: one-cycle request, router busy for 5 more cycles.
    reset_req_i  = 1'b1;
    drain_idle_i = 1'b0;
    step("drn");
    reset_req_i = 1'b0;
    for (int e = 0; e < 5; e++) begin
      step("drn");
      chk("drn/wait_a", 32'(reset_a), 32'h0);
      chk("drn/wait_done_a", 32'(done_a), 32'd0);
    end
    drain_idle_i = 1'b1;
    step("drn");
    chk("drn/assert_a", 32'(reset_a), 32'h3);
    chk("drn/no_timeout_a", 32'(timeout_a), 32'd0);
    chk("drn/no_timeout_b", 32'(timeout_b), 32'd0);
    for (int e = 1; e <= 24; e++) begin
      step("drn_rel");
      if (e == 23) chk("drn/e23_done_a", 32'(done_a), 32'd0);
      if (e == 24) chk("drn/e24_a", 32'(reset_a), 32'h0);
    end
    settle("drn_settle");
    $display("txn drain-then-reset: errors=%0d checks=%0d", errors, checks);

    // Drain timeout on instance B (8-cycle limit), router never idles.
    reset_req_i  = 1'b1;
    drain_idle_i = 1'b0;
    step("tmo");
    reset_req_i = 1'b0;
    for (int e = 2; e <= 9; e++) begin
      step("tmo");
      if (e < 9) chk("tmo/early_b", 32'(timeout_b), 32'd0);
      if (e == 9) begin
        chk("tmo/pulse_b", 32'(timeout_b), 32'd1);
        chk("tmo/reset_b", 32'(reset_b), 32'h7);
        chk("tmo/a_still_draining", 32'(reset_a), 32'h0);
      end
    end
    step("tmo");
    chk("tmo/after_b", 32'(timeout_b), 32'd0);
    drain_idle_i = 1'b1;
    settle("tmo_settle");
    $display("txn drain-timeout: errors=%0d checks=%0d", errors, checks);

    // Extended request: held for 40 cycles after ASSERT entry.
    reset_req_i = 1'b1;
    step("ext");
    step("ext");
    chk("ext/entry_a", 32'(reset_a), 32'h3);
    for (int e = 1; e <= 40; e++) begin
      step("ext");
      chk("ext/held_a", 32'(reset_a), 32'h3);
    end
    reset_req_i = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step("ext_rel");
      if (e <= 4) chk("ext/pre_rel_a", 32'(reset_a), 32'h3);
      if (e == 5) begin
        chk("ext/first_rel_a", 32'(reset_a), 32'h2);
        chk("ext/first_rel_b", 32'(reset_b), 32'h6);
      end
    end
    settle("ext_settle");
    $display("txn extended-request: errors=%0d checks=%0d", errors, checks);

    // Re-request while instance B is part-way through release.
    reset_req_i = 1'b1;
    step("rrq");
    reset_req_i = 1'b0;
    step("rrq");
    for (int k = 0; k < 100 && exp_reset(1) != 32'h6; k++) step("rrq_wait");
    chk("rrq/at_110_b", 32'(reset_b), 32'h6);
    reset_req_i = 1'b1;
    step("rrq");
    chk("rrq/reassert_b", 32'(reset_b), 32'h7);
    reset_req_i = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step("rrq_hold");
      if (e <= 16) chk("rrq/hold_b", 32'(reset_b), 32'h7);
      if (e == 20) chk("rrq/rel_b", 32'(reset_b), 32'h6);
    end
    settle("rrq_settle");
    $display("txn re-request: errors=%0d checks=%0d", errors, checks);

    // Randomized traffic: sparse requests, slowly toggling drain status,
    // occasional resets.
    for (int i = 0; i < 2000; i++) begin
      reset_i     = ($urandom_range(0, 199) == 0);
      reset_req_i = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) drain_idle_i = ~drain_idle_i;
      step("rnd");
    end
    reset_i      = 1'b0;
    reset_req_i  = 1'b0;
    drain_idle_i = 1'b1;
    settle("rnd_settle");
    $display("txn random: errors=%0d checks=%0d", errors, checks);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
